// File: rtl/alu_issue_ctrl_if.sv
// Issue-side bundle for alu_issue_ctrl: instruction handshake plus the ALU
// operand/result channel that the controller sequences.
interface alu_issue_ctrl_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] alu_reg1;
  logic [31:0] alu_reg2;
  logic [15:0] alu_iv;
  logic [3:0]  alu_opcode;
  logic [3:0]  alu_cond;
  logic        alu_s;
  logic [3:0]  alu_flag;
  logic [31:0] alu_result;
  logic [3:0]  alu_new_flag;

  modport master (
    output instr, instr_valid, alu_result, alu_new_flag,
    input  instr_ready, alu_reg1, alu_reg2, alu_iv, alu_opcode, alu_cond, alu_s, alu_flag
  );

  modport slave (
    input  instr, instr_valid, alu_result, alu_new_flag,
    output instr_ready, alu_reg1, alu_reg2, alu_iv, alu_opcode, alu_cond, alu_s, alu_flag
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Four-state issue controller: accepts one instruction, reads operands, presents
// them to an external ALU for one cycle, then conditionally writes back.
module alu_issue_ctrl #(
  parameter int NREG = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_issue_ctrl_if.slave    bus,
  output logic [3:0]         flags,
  output logic               done,
  output logic               skipped,
  output logic               illegal,
  input  logic [2:0]         dbg_addr,
  output logic [31:0]        dbg_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  localparam logic [3:0] OP_MOVN = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_CMP  = 4'hB;

  state_t      state_r;
  logic [31:0] regs_r [NREG];
  logic [3:0]  flags_r;

  logic [3:0]  cond_r;
  logic [3:0]  opcode_r;
  logic        s_r;
  logic [2:0]  rd_r;
  logic [2:0]  rn_r;
  logic [2:0]  rm_r;
  logic [15:0] iv_r;
  logic [31:0] rm_val_r;

  logic        instr_ready_r;
  logic [31:0] alu_reg1_r;
  logic [31:0] alu_reg2_r;
  logic [15:0] alu_iv_r;
  logic [3:0]  alu_opcode_r;
  logic [3:0]  alu_cond_r;
  logic        alu_s_r;
  logic [3:0]  alu_flag_r;

  logic        done_r;
  logic        skipped_r;
  logic        illegal_r;
  logic        wb_reg_we_r;
  logic        wb_flag_we_r;
  logic [31:0] wb_data_r;
  logic [3:0]  wb_flags_r;

  logic        unused_s;

  // Flags are {N,Z,C,V}; returns whether the condition code passes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, p;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'h0:    p = z;
      4'h1:    p = !z;
      4'h2:    p = c;
      4'h3:    p = !c;
      4'h4:    p = n;
      4'h5:    p = !n;
      4'h6:    p = v;
      4'h7:    p = !v;
      4'h8:    p = c & !z;
      4'h9:    p = !c | z;
      4'hA:    p = (n == v);
      4'hB:    p = (n != v);
      4'hC:    p = !z & (n == v);
      4'hD:    p = z | (n != v);
      4'hE:    p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  // Opcodes whose result comes from the external ALU and honour S.
  function automatic logic is_alu_op(input logic [3:0] op);
    logic r;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA: r = 1'b1;
      default:                                               r = 1'b0;
    endcase
    return r;
  endfunction

  assign bus.instr_ready = instr_ready_r;
  assign bus.alu_reg1    = alu_reg1_r;
  assign bus.alu_reg2    = alu_reg2_r;
  assign bus.alu_iv      = alu_iv_r;
  assign bus.alu_opcode  = alu_opcode_r;
  assign bus.alu_cond    = alu_cond_r;
  assign bus.alu_s       = alu_s_r;
  assign bus.alu_flag    = alu_flag_r;
  assign flags           = flags_r;
  assign done            = done_r;
  assign skipped         = skipped_r;
  assign illegal         = illegal_r;
  assign dbg_data        = regs_r[dbg_addr];
  assign unused_s        = bus.instr[16];

  // Sequencer, register file, flag register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      for (int i = 0; i < NREG; i++) regs_r[i] <= 32'h0;
      flags_r       <= 4'h0;
      cond_r        <= 4'h0;
      opcode_r      <= 4'h0;
      s_r           <= 1'b0;
      rd_r          <= 3'd0;
      rn_r          <= 3'd0;
      rm_r          <= 3'd0;
      iv_r          <= 16'h0;
      rm_val_r      <= 32'h0;
      instr_ready_r <= 1'b1;
      alu_reg1_r    <= 32'h0;
      alu_reg2_r    <= 32'h0;
      alu_iv_r      <= 16'h0;
      alu_opcode_r  <= 4'h0;
      alu_cond_r    <= 4'h0;
      alu_s_r       <= 1'b0;
      alu_flag_r    <= 4'h0;
      done_r        <= 1'b0;
      skipped_r     <= 1'b0;
      illegal_r     <= 1'b0;
      wb_reg_we_r   <= 1'b0;
      wb_flag_we_r  <= 1'b0;
      wb_data_r     <= 32'h0;
      wb_flags_r    <= 4'h0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.instr_valid) begin
            cond_r        <= bus.instr[31:28];
            opcode_r      <= bus.instr[27:24];
            s_r           <= bus.instr[23];
            rd_r          <= bus.instr[22:20];
            rn_r          <= bus.instr[19:17];
            rm_r          <= bus.instr[2:0];
            iv_r          <= bus.instr[15:0];
            instr_ready_r <= 1'b0;
            state_r       <= DECODE;
          end else begin
            instr_ready_r <= 1'b1;
          end
        end
        DECODE: begin
          alu_reg1_r   <= regs_r[rn_r];
          alu_reg2_r   <= regs_r[rm_r];
          rm_val_r     <= regs_r[rm_r];
          alu_iv_r     <= iv_r;
          alu_opcode_r <= opcode_r;
          alu_cond_r   <= cond_r;
          alu_s_r      <= s_r | (opcode_r == OP_CMP);
          alu_flag_r   <= flags_r;
          state_r      <= EXEC;
        end
        EXEC: begin
          // Opcodes 1100-1111 are illegal regardless of condition.
          done_r       <= 1'b1;
          illegal_r    <= (opcode_r[3:2] == 2'b11);
          skipped_r    <= (opcode_r[3:2] != 2'b11) & !cond_pass(cond_r, flags_r);
          wb_reg_we_r  <= (opcode_r[3:2] != 2'b11) & cond_pass(cond_r, flags_r) &
                          (is_alu_op(opcode_r) | (opcode_r == OP_MOVN) | (opcode_r == OP_MOV));
          wb_flag_we_r <= (opcode_r[3:2] != 2'b11) & cond_pass(cond_r, flags_r) &
                          ((is_alu_op(opcode_r) & s_r) | (opcode_r == OP_CMP));
          wb_flags_r   <= bus.alu_new_flag;
          if (opcode_r == OP_MOVN) begin
            wb_data_r <= {16'h0000, iv_r};
          end else if (opcode_r == OP_MOV) begin
            wb_data_r <= rm_val_r;
          end else begin
            wb_data_r <= bus.alu_result;
          end
          alu_reg1_r   <= 32'h0;
          alu_reg2_r   <= 32'h0;
          alu_iv_r     <= 16'h0;
          alu_opcode_r <= 4'h0;
          alu_cond_r   <= 4'h0;
          alu_s_r      <= 1'b0;
          alu_flag_r   <= 4'h0;
          state_r      <= WB;
        end
        WB: begin
          if (wb_reg_we_r) begin
            regs_r[rd_r] <= wb_data_r;
          end else begin
            regs_r[rd_r] <= regs_r[rd_r];
          end
          if (wb_flag_we_r) begin
            flags_r <= wb_flags_r;
          end else begin
            flags_r <= flags_r;
          end
          done_r        <= 1'b0;
          skipped_r     <= 1'b0;
          illegal_r     <= 1'b0;
          wb_reg_we_r   <= 1'b0;
          wb_flag_we_r  <= 1'b0;
          instr_ready_r <= 1'b1;
          state_r       <= IDLE;
        end
        default: begin
          instr_ready_r <= 1'b1;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with hand-computed expectations.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  flags;
  logic        done;
  logic        skipped;
  logic        illegal;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks;
  int errors;

  logic [31:0] mreg [8];
  logic [3:0]  exp_flags;

  logic [31:0] prog     [3];
  logic [31:0] prog_res [3];
  logic [31:0] prog_r1  [3];
  logic [31:0] prog_r2  [3];

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(.NREG(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flags    (flags),
    .done     (done),
    .skipped  (skipped),
    .illegal  (illegal),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [31:0] mk(input logic [3:0] cond, input logic [3:0] op,
                                     input logic s, input logic [2:0] rd,
                                     input logic [2:0] rn, input logic [15:0] iv);
    return {cond, op, s, rd, rn, 1'b0, iv};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = i[2:0];
      #1;
      chk($sformatf("reg%0d", i), dbg_data, mreg[i]);
    end
    chk("flags", {28'h0, flags}, {28'h0, exp_flags});
  endtask

  // Runs one instruction from IDLE through WB, checking every phase.
  task automatic do_instr(input logic [31:0] ins, input logic [31:0] res, input logic [3:0] nf,
                          input logic [31:0] e_r1, input logic [31:0] e_r2,
                          input logic e_skip, input logic e_ill);
    bus.instr        = ins;
    bus.instr_valid  = 1'b1;
    bus.alu_result   = res;
    bus.alu_new_flag = nf;
    dbg_addr         = ins[22:20];
    chk("ready_idle", {31'h0, bus.instr_ready}, 32'd1);
    tick();
    bus.instr_valid = 1'b0;
    chk("ready_decode", {31'h0, bus.instr_ready}, 32'd0);
    chk("done_decode", {31'h0, done}, 32'd0);
    chk("reg1_decode_zero", bus.alu_reg1, 32'h0);
    tick();
    chk("ready_exec", {31'h0, bus.instr_ready}, 32'd0);
    chk("alu_reg1", bus.alu_reg1, e_r1);
    chk("alu_reg2", bus.alu_reg2, e_r2);
    chk("alu_opcode", {28'h0, bus.alu_opcode}, {28'h0, ins[27:24]});
    chk("alu_cond", {28'h0, bus.alu_cond}, {28'h0, ins[31:28]});
    chk("alu_iv", {16'h0, bus.alu_iv}, {16'h0, ins[15:0]});
    chk("alu_s", {31'h0, bus.alu_s}, {31'h0, ins[23] | (ins[27:24] == 4'hB)});
    chk("alu_flag", {28'h0, bus.alu_flag}, {28'h0, exp_flags});
    tick();
    chk("done_wb", {31'h0, done}, 32'd1);
    chk("skipped_wb", {31'h0, skipped}, {31'h0, e_skip});
    chk("illegal_wb", {31'h0, illegal}, {31'h0, e_ill});
    chk("dbg_prewrite", dbg_data, mreg[ins[22:20]]);
    chk("opcode_wb_zero", {28'h0, bus.alu_opcode}, 32'h0);
    tick();
    chk("done_after", {31'h0, done}, 32'd0);
    chk("ready_after", {31'h0, bus.instr_ready}, 32'd1);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    exp_flags        = 4'h0;
    for (int i = 0; i < 8; i++) mreg[i] = 32'h0;
    rst              = 1'b1;
    dbg_addr         = 3'd0;
    bus.instr        = mk(4'hE, 4'h6, 1'b0, 3'd1, 3'd0, 16'h00AA);
    bus.instr_valid  = 1'b1;
    bus.alu_result   = 32'h0;
    bus.alu_new_flag = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    rst             = 1'b0;
    bus.instr_valid = 1'b0;
    chk("rst_ready", {31'h0, bus.instr_ready}, 32'd1);
    chk("rst_done", {29'h0, done, skipped, illegal}, 32'd0);
    chk("rst_alu_reg1", bus.alu_reg1, 32'h0);
    check_state();

    // MOVn r1,#5 ; MOVn r2,#3 ; ADD S=1 r3=r1+r2
    do_instr(mk(4'hE, 4'h6, 1'b0, 3'd1, 3'd0, 16'h0005), 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    mreg[1] = 32'd5;
    do_instr(mk(4'hE, 4'h6, 1'b0, 3'd2, 3'd0, 16'h0003), 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    mreg[2] = 32'd3;
    do_instr(mk(4'hE, 4'h0, 1'b1, 3'd3, 3'd1, 16'h0002), 32'd8, 4'h0, 32'd5, 32'd3, 1'b0, 1'b0);
    mreg[3] = 32'd8;
    check_state();

    // CMP r1,r1 -> Z; EQ MOV r4,r2 passes; NE MOV r5,r2 skips
    do_instr(mk(4'hE, 4'hB, 1'b0, 3'd0, 3'd1, 16'h0001), 32'h0, 4'b0100, 32'd5, 32'd5, 1'b0, 1'b0);
    exp_flags = 4'b0100;
    do_instr(mk(4'h0, 4'h7, 1'b0, 3'd4, 3'd0, 16'h0002), 32'hDEADBEEF, 4'hF, 32'h0, 32'd3, 1'b0, 1'b0);
    mreg[4] = 32'd3;
    do_instr(mk(4'h1, 4'h7, 1'b0, 3'd5, 3'd0, 16'h0002), 32'hDEADBEEF, 4'hF, 32'h0, 32'd3, 1'b1, 1'b0);
    check_state();

    // SUB S=0 writes rd but leaves flags
    do_instr(mk(4'hE, 4'h1, 1'b0, 3'd6, 3'd1, 16'h0002), 32'd2, 4'hF, 32'd5, 32'd3, 1'b0, 1'b0);
    mreg[6] = 32'd2;
    // Illegal opcode 1101 and never-condition ADD
    do_instr(mk(4'hE, 4'hD, 1'b1, 3'd1, 3'd0, 16'h0000), 32'd99, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1);
    do_instr(mk(4'hF, 4'h0, 1'b1, 3'd7, 3'd1, 16'h0002), 32'd77, 4'hF, 32'd5, 32'd3, 1'b1, 1'b0);
    check_state();

    // Reset during EXEC of ADD r6 discards it
    bus.instr        = mk(4'hE, 4'h0, 1'b1, 3'd6, 3'd1, 16'h0002);
    bus.instr_valid  = 1'b1;
    bus.alu_result   = 32'd123;
    bus.alu_new_flag = 4'hF;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    chk("rst_exec_reg1", bus.alu_reg1, 32'd5);
    rst             = 1'b1;
    bus.instr_valid = 1'b1;
    tick();
    rst             = 1'b0;
    bus.instr_valid = 1'b0;
    chk("rst_exec_done", {31'h0, done}, 32'd0);
    chk("rst_exec_ready", {31'h0, bus.instr_ready}, 32'd1);
    chk("rst_exec_reg1_zero", bus.alu_reg1, 32'h0);
    for (int i = 0; i < 8; i++) mreg[i] = 32'h0;
    exp_flags = 4'h0;
    check_state();
    tick();
    chk("post_rst_ready", {31'h0, bus.instr_ready}, 32'd1);
    chk("post_rst_done", {31'h0, done}, 32'd0);

    // Back-to-back with valid held high: MOVn r1,#7 ; ADD r2=r1+r1 ; ADD r3=r2+r1
    prog[0] = mk(4'hE, 4'h6, 1'b0, 3'd1, 3'd0, 16'h0007);
    prog[1] = mk(4'hE, 4'h0, 1'b0, 3'd2, 3'd1, 16'h0001);
    prog[2] = mk(4'hE, 4'h0, 1'b0, 3'd3, 3'd2, 16'h0001);
    prog_res[0] = 32'h0;  prog_r1[0] = 32'h0;  prog_r2[0] = 32'h0;
    prog_res[1] = 32'd14; prog_r1[1] = 32'd7;  prog_r2[1] = 32'd7;
    prog_res[2] = 32'd21; prog_r1[2] = 32'd14; prog_r2[2] = 32'd7;
    bus.instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.instr      = prog[k];
      bus.alu_result = prog_res[k];
      chk("b2b_ready_idle", {31'h0, bus.instr_ready}, 32'd1);
      chk("b2b_done_idle", {31'h0, done}, 32'd0);
      tick();
      chk("b2b_ready_decode", {31'h0, bus.instr_ready}, 32'd0);
      tick();
      chk("b2b_reg1", bus.alu_reg1, prog_r1[k]);
      chk("b2b_reg2", bus.alu_reg2, prog_r2[k]);
      tick();
      chk("b2b_done_wb", {31'h0, done}, 32'd1);
      tick();
    end
    bus.instr_valid = 1'b0;
    mreg[1] = 32'd7;
    mreg[2] = 32'd14;
    mreg[3] = 32'd21;
    check_state();
    tick();
    chk("idle_no_done", {31'h0, done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
